// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and bit-reverse helper for the streaming CRC engine.
package crc_pkg;

  localparam logic [15:0] CRC16_IBM_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_XOROUT   = 16'h0000;
  localparam logic [15:0] CRC16_RESIDUE  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRAME  = 2'd1,
    APPEND = 2'd2
  } state_t;

  // Reverses the low w bits of v; result is right-aligned.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      r[31-i] = v[i];
    end
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/crc_step_comb.sv
// One-byte combinational CRC step, register kept in normal (MSB-first) form.
module crc_step_comb
  import crc_pkg::*;
#(
  parameter int               CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = CRC16_IBM_POLY,
  parameter bit               REFIN = 1'b1
) (
  input  logic [CRC_W-1:0] i_crc,
  input  logic [7:0]       i_byte,
  output logic [CRC_W-1:0] o_crc
);

  logic [7:0]       w_byte_rev;
  logic [7:0]       w_byte;
  logic [CRC_W-1:0] w_crc;
  logic             w_fb;

  // Reflected input feeds bit 0 first, so reverse it and keep a single MSB-first loop.
  always_comb begin
    w_byte_rev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_byte_rev[i] = i_byte[7-i];
    end
    w_byte = REFIN ? w_byte_rev : i_byte;
    w_crc  = i_crc;
    w_fb   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      w_fb  = w_crc[CRC_W-1] ^ w_byte[i];
      w_crc = {w_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : {CRC_W{1'b0}});
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker with one-stage pass-through register.
// Optional feature: define CRC_APPEND_EN to append crc_out (LS byte first) after each eof beat.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC16_IBM_POLY,
  parameter logic [CRC_W-1:0] INIT    = CRC16_INIT,
  parameter bit               REFIN   = 1'b1,
  parameter bit               REFOUT  = 1'b1,
  parameter logic [CRC_W-1:0] XOROUT  = CRC16_XOROUT,
  parameter logic [CRC_W-1:0] RESIDUE = CRC16_RESIDUE
) (
  input  logic              sclk,
  input  logic              rest,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_eof,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok,
  output logic              busy
);

  localparam int NB = DATA_W / 8;

  state_t            r_state, w_state_nxt;
  logic [CRC_W-1:0]  r_crc, r_crc_out;
  logic              r_crc_valid, r_crc_ok;
  logic              r_m_valid, r_m_eof;
  logic [DATA_W-1:0] r_m_data;
  logic              w_fire, w_m_free;
  logic [CRC_W-1:0]  w_seed, w_crc_nxt, w_final;
  logic [31:0]       w_rev_full;

  assign w_m_free = !r_m_valid || m_ready;
  assign w_fire   = s_valid && s_ready;
  assign w_seed   = (s_sof || r_state == IDLE) ? INIT : r_crc;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [CRC_W-1:0] w_in, w_out;
    if (g == 0) begin : g_first
      assign w_in = w_seed;
    end else begin : g_next
      assign w_in = g_lane[g-1].w_out;
    end
    crc_step_comb #(.CRC_W(CRC_W), .POLY(POLY), .REFIN(REFIN)) u_step (
      .i_crc  (w_in),
      .i_byte (s_data[8*g +: 8]),
      .o_crc  (w_out)
    );
  end

  assign w_crc_nxt  = g_lane[NB-1].w_out;
  assign w_rev_full = bit_rev32(32'(w_crc_nxt), CRC_W);
  assign w_final    = (REFOUT ? w_rev_full[CRC_W-1:0] : w_crc_nxt) ^ XOROUT;

`ifdef CRC_APPEND_EN
  localparam int APP_BEATS = CRC_W / DATA_W;
  logic [2:0] r_app_cnt;
  logic       w_app_load, w_app_last;
  assign w_app_last = (r_app_cnt == 3'(APP_BEATS - 1));
`endif

  // Next-state and accept logic.
  always_comb begin
    w_state_nxt = r_state;
`ifdef CRC_APPEND_EN
    w_app_load  = 1'b0;
`endif
    case (r_state)
      IDLE, FRAME: begin
        if (w_fire && s_eof) begin
`ifdef CRC_APPEND_EN
          w_state_nxt = APPEND;
`else
          w_state_nxt = IDLE;
`endif
        end else if (w_fire) begin
          w_state_nxt = FRAME;
        end else begin
          w_state_nxt = r_state;
        end
      end
`ifdef CRC_APPEND_EN
      APPEND: begin
        w_app_load  = w_m_free;
        w_state_nxt = (w_m_free && w_app_last) ? IDLE : APPEND;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
    s_ready = w_m_free && (r_state != APPEND);
  end

  always_ff @(posedge sclk or posedge rest) begin
    if (rest) begin
      r_state     <= IDLE;
      r_crc       <= INIT;
      r_crc_out   <= {CRC_W{1'b0}};
      r_crc_valid <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= {DATA_W{1'b0}};
      r_m_eof     <= 1'b0;
`ifdef CRC_APPEND_EN
      r_app_cnt   <= 3'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_crc_valid <= w_fire && s_eof;
      if (w_fire) begin
        r_crc <= s_eof ? INIT : w_crc_nxt;
      end
      if (w_fire && s_eof) begin
        r_crc_out <= w_final;
        r_crc_ok  <= (w_final == RESIDUE);
      end
      // Output register: new input beat, appended CRC beat, or drain.
      if (w_m_free) begin
        if (w_fire) begin
          r_m_valid <= 1'b1;
          r_m_data  <= s_data;
`ifdef CRC_APPEND_EN
          r_m_eof   <= 1'b0;
`else
          r_m_eof   <= s_eof;
`endif
`ifdef CRC_APPEND_EN
        end else if (w_app_load) begin
          r_m_valid <= 1'b1;
          r_m_data  <= r_crc_out[r_app_cnt*DATA_W +: DATA_W];
          r_m_eof   <= w_app_last;
`endif
        end else begin
          r_m_valid <= 1'b0;
        end
      end
`ifdef CRC_APPEND_EN
      if (w_app_load) begin
        r_app_cnt <= w_app_last ? 3'd0 : r_app_cnt + 3'd1;
      end
`endif
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_eof     = r_m_eof;
  assign crc_valid = r_crc_valid;
  assign crc_out   = r_crc_out;
  assign crc_ok    = r_crc_ok;
  assign busy      = (r_state != IDLE);

endmodule
